// File: rtl/fp_mul_sched_pkg.sv
// Shared constants, ID-width helper and shadow-stage record for the
// multiplier scheduler.
package fp_mul_sched_pkg;

  localparam int FP_PRECISION   = 32;
  localparam int FP_MUL_LATENCY = 5;
  // Widest requester ID needed for the supported range of N_REQ (2..16).
  localparam int MAX_ID_W       = 4;

  function automatic int id_width(input int n_req);
    return (n_req > 2) ? $clog2(n_req) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } shadow_stage_t;

endpackage

// File: rtl/fp_mul_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching from the pointer,
// pointer advances past the winner only when the grant is taken.
module rr_arbiter
  import fp_mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic            grant_any;
  logic [ID_W-1:0] cand_idx [N_REQ];

  // cand_idx[gi] is the requester at search offset gi; ptr < N_REQ, so a
  // single conditional subtract gives the modulo for any N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [ID_W:0] sum;
    assign sum = {1'b0, ptr_reg} + (ID_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                     : sum[ID_W-1:0];
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    // Walk from the farthest offset so the nearest valid requester wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (enable && req[cand_idx[i]]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant[gi] = grant_any && (grant_idx == ID_W'(gi));
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance) begin
      ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one fixed-latency pipelined FP multiplier among N_REQ requesters;
// a shadow pipeline carries each op's requester ID to steer its result back.
module fp_mul_sched
  import fp_mul_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PRECISION = FP_PRECISION,
  parameter int LATENCY   = FP_MUL_LATENCY,
  parameter int ID_W      = id_width(N_REQ),
  parameter int CNT_W     = $clog2(LATENCY + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*PRECISION-1:0] req_a,
  input  logic [N_REQ*PRECISION-1:0] req_b,
  input  logic                       hold,
  output logic [PRECISION-1:0]       mul_a,
  output logic [PRECISION-1:0]       mul_b,
  input  logic [PRECISION-1:0]       mul_result,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [PRECISION-1:0]       resp_data,
  output logic                       busy,
  output logic [CNT_W-1:0]           inflight
);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             arb_enable;
  logic             issue;
  logic             retire;

  // No grants while reset is held so req_ready and the operand bus stay at 0.
  assign arb_enable = ~hold & reset_n;
  assign issue      = |(req_valid & grant);
  assign req_ready  = grant;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .enable    (arb_enable),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  logic [PRECISION-1:0] a_masked [N_REQ];
  logic [PRECISION-1:0] b_masked [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_opmux
    assign a_masked[gi] = grant[gi] ? req_a[gi*PRECISION +: PRECISION] : '0;
    assign b_masked[gi] = grant[gi] ? req_b[gi*PRECISION +: PRECISION] : '0;
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mul_a = mul_a | a_masked[i];
      mul_b = mul_b | b_masked[i];
    end
  end

  shadow_stage_t shadow_reg [LATENCY];
  shadow_stage_t stage_in;
  shadow_stage_t tail;

  always_comb begin
    stage_in.valid = issue;
    stage_in.id    = issue ? MAX_ID_W'(grant_idx) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        shadow_reg[i] <= '0;
      end
    end else begin
      shadow_reg[0] <= stage_in;
      for (int i = 1; i < LATENCY; i++) begin
        shadow_reg[i] <= shadow_reg[i-1];
      end
    end
  end

  // The last shadow stage lines up with mul_result for the same operation.
  assign tail   = shadow_reg[LATENCY-1];
  assign retire = tail.valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
    assign resp_valid[gi] = tail.valid && (tail.id == MAX_ID_W'(gi));
  end

  assign resp_data = tail.valid ? mul_result : '0;

  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] inflight_next;

  always_comb begin
    inflight_next = inflight_reg;
    if (issue && !retire) begin
      inflight_next = inflight_reg + CNT_W'(1);
    end else if (!issue && retire) begin
      inflight_next = inflight_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  assign inflight = inflight_reg;
  assign busy     = (inflight_reg != '0);

endmodule

// File: doc/fp_mul_sched.md
Name: fp_mul_sched

Overview:
- Round-robin scheduler that shares one fixed-latency, fully pipelined IEEE-754 single-precision multiplier among N_REQ requesters, e.g. the parallel chaotic-map lanes of the encryption core.
- Accepts at most one operand pair per cycle and drives the multiplier operand bus.
- Tracks each issued operation's requester ID through a LATENCY-deep shadow pipeline, then steers the result back to the originating requester with a one-cycle valid pulse.
- The multiplier has no valid or stall signal, so all sequencing lives in this block.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- PRECISION, 32, operand/result width.
- LATENCY, 5, multiplier latency: number of clk edges from operands driven to result valid.
- ID_W, $clog2(N_REQ), requester-ID width (derived).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_a  in  N_REQ*PRECISION  operand A, requester i at slice [i*PRECISION +: PRECISION].
- req_b  in  N_REQ*PRECISION  operand B, same packing as req_a.
- hold  in  1  1 blocks new grants; in-flight operations still complete.
- mul_a  out  PRECISION  multiplier operand A.
- mul_b  out  PRECISION  multiplier operand B.
- mul_result  in  PRECISION  multiplier result.
- resp_valid  out  N_REQ  one-hot result strobe.
- resp_data  out  PRECISION  result data, valid when any resp_valid bit is set.
- busy  out  1  at least one operation in flight.
- inflight  out  $clog2(LATENCY+1)  count of in-flight operations.

Behaviour:
Reset:
- reset_n low asynchronously clears the shadow pipeline (all valid bits 0, IDs 0) and sets the RR pointer to 0.
- Outputs during and after reset: req_ready=0, resp_valid=0, busy=0, inflight=0.
- mul_a, mul_b and resp_data are don't-care, but reset drives them to 0 (grant mux selects nothing).

Grant:
- Combinational from req_valid, hold and the RR pointer.
- If hold=0 and any req_valid is set: grant the first set bit searching ptr, ptr+1, …, wrapping modulo N_REQ.
- req_ready[g]=1 only for the granted requester. No grant → req_ready=0.
- req_ready never depends on resp_valid, so no combinational loop.

Issue:
- Handshake = req_valid[g] & req_ready[g], sampled on clk edge k.
- In the same cycle, mul_a/mul_b carry req_a/req_b of g through a combinational mux. With no grant, they carry 0.
- At edge k, shadow stage 0 captures {1, g}. Each later edge shifts the shadow pipeline one stage.
- RR pointer at edge k becomes (g+1) mod N_REQ. With no handshake the pointer holds.
- Throughput: one issue per cycle. A lone requester with req_valid held high issues every cycle.

Response:
- Shadow stage LATENCY-1 is valid in the cycle after edge k+LATENCY-1, aligned with mul_result for that operation.
- resp_valid = onehot(id) when that stage is valid, else 0. resp_data = mul_result, passed through.
- Handshake-to-resp_valid latency is exactly LATENCY cycles.
- Requesters must accept responses unconditionally; there is no response backpressure.
- Results return in issue order.

Counters:
- inflight = number of valid shadow stages, registered.
- On each edge: +1 on issue, -1 on retire, unchanged when both occur. Max value LATENCY.
- busy = (inflight != 0).

Boundary conditions:
- hold asserted mid-stream: grants stop that cycle. Shadow stages drain, with a response each cycle, until busy=0.
- req_valid dropped while granted: no handshake, pointer unchanged.
- All N_REQ valid continuously: grants rotate 0,1,2,3,0,… with no requester starved for more than N_REQ-1 cycles.
- Reset asserted with operations in flight: those responses are discarded and never emitted.
- Pointer wrap: ptr = N_REQ-1 wraps to 0. Non-power-of-2 N_REQ must wrap correctly (e.g. N_REQ=3: 2→0).

Decomposition:
- Package fp_mul_sched_pkg: PRECISION default, FP_MUL_LATENCY=5, ID width function, and the shadow-stage struct {valid, id}.
- Sub-module rr_arbiter (N_REQ): req, enable, and advance inputs; one-hot grant and grant-index outputs; owns the pointer.
- The shadow pipeline and response steering stay in the top module.

Test Plan:
1. Reset, then only requester 2 issues a=0x40000000 (2.0), b=0x40400000 (3.0) → req_ready=0b0100 same cycle; 5 cycles later resp_valid=0b0100, resp_data=0x40C00000 (6.0); inflight 1 then back to 0.
2. All four requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses arrive in the same order starting at cycle 5; inflight saturates at 5.
3. Requester 1 valid alone for 6 cycles with distinct operands → 6 back-to-back handshakes; 6 consecutive resp_valid=0b0010 pulses in issue order.
4. Three in flight, then hold=1 with all req_valid high → req_ready=0 while hold=1; exactly 3 responses drain; busy falls after the last; releasing hold resumes RR from the saved pointer.
5. Reset asserted 2 cycles after 2 issues → no resp_valid ever appears for them; inflight=0 and busy=0 immediately after reset.
6. N_REQ=3 build, all valid → grants 0,1,2,0,1,2 (pointer wraps 2→0); requester 1 dropping req_valid while granted causes no handshake and no pointer advance.
